// File: rtl/tlb_probe_unit.sv
// tlb_probe_unit: sequential TLBP engine scanning 32 TLB headers through read port C.
module tlb_probe_unit #(
  parameter int ENTRIES = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] entry_hi_i,
  input  logic        tlb_we_i,
  input  logic [4:0]  tlbr_index_i,
  output logic [4:0]  index_c_o,
  input  logic [43:0] header_c_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] index_result_o,
  output logic        multi_hit_o
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [4:0] LAST = 5'(ENTRIES - 1);
  state_t      state_q, state_d;
  logic [18:0] vpn2_q, vpn2_d;
  logic [7:0]  asid_q, asid_d;
  logic [4:0]  cnt_q, cnt_d, idx_q, idx_d;
  logic        found_q, found_d, multi_q, multi_d, mh_q, mh_d;
  logic [31:0] res_q, res_d;
  logic [18:0] mask;
  logic        hit;
  logic        unused_ehi;
  assign unused_ehi = ^entry_hi_i[12:8];
  assign mask = {3'b000, header_c_i[43:28]};
  assign hit = (((header_c_i[27:9] ^ vpn2_q) & ~mask) == 19'd0) &&
               (header_c_i[0] || header_c_i[8:1] == asid_q);
  assign busy_o = state_q == SCAN;
  assign done_o = state_q == DONE;
  assign index_c_o = busy_o ? cnt_q : tlbr_index_i;
  assign index_result_o = res_q;
  assign multi_hit_o = mh_q;
  always_comb begin
    state_d = state_q;
    vpn2_d = vpn2_q;
    asid_d = asid_q;
    cnt_d = cnt_q;
    found_d = found_q;
    idx_d = idx_q;
    multi_d = multi_q;
    res_d = res_q;
    mh_d = mh_q;
    unique case (state_q)
      SCAN: begin
        if (tlb_we_i) begin
          cnt_d = 5'd0;
          found_d = 1'b0;
          idx_d = 5'd0;
          multi_d = 1'b0;
        end else begin
          // lowest matching index wins; later hits only flag multi
          found_d = found_q | hit;
          idx_d = (hit && !found_q) ? cnt_q : idx_q;
          multi_d = multi_q | (hit & found_q);
          if (cnt_q == LAST) begin
            state_d = DONE;
            res_d = {~found_d, 26'b0, found_d ? idx_d : 5'd0};
            mh_d = multi_d;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = start_i ? SCAN : IDLE;
        if (start_i) begin
          vpn2_d = entry_hi_i[31:13];
          asid_d = entry_hi_i[7:0];
          cnt_d = 5'd0;
          found_d = 1'b0;
          idx_d = 5'd0;
          multi_d = 1'b0;
        end
      end
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      vpn2_q <= '0;
      asid_q <= '0;
      cnt_q <= '0;
      found_q <= 1'b0;
      idx_q <= '0;
      multi_q <= 1'b0;
      res_q <= 32'h8000_0000;
      mh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vpn2_q <= vpn2_d;
      asid_q <= asid_d;
      cnt_q <= cnt_d;
      found_q <= found_d;
      idx_q <= idx_d;
      multi_q <= multi_d;
      res_q <= res_d;
      mh_q <= mh_d;
    end
  end
endmodule
